// File: rtl/seven_seg_pkg.sv
// Shared types and the segment code table for seven-segment encode/decode.
// Segment vectors are active-low, bit0=A .. bit6=G.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] hex_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Index is the hex value shown by that pattern.
  localparam seg_t SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } rd_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational inverse of the segment encoder: pattern -> hex value plus match flag.
// Unlisted patterns (blank included) report match_o=0 and hex_o=0.
module seg_decode
  import seven_seg_pkg::*;
(
  input  seg_t seg_i,
  output hex_t hex_o,
  output logic match_o
);

  always_comb begin
    hex_o   = '0;
    match_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_CODES[i]) begin
        hex_o   = hex_t'(i);
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Passive snooper for a multiplexed common-anode display: synchronise, debounce,
// and commit one decoded digit per stable anode window.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [6:0]                    seg,
  input  logic [NUM_DIGITS-1:0]         an,
  output logic [4*NUM_DIGITS-1:0]       digits_o,
  output logic [NUM_DIGITS-1:0]         valid_o,
  output logic [NUM_DIGITS-1:0]         err_o,
  output logic                          upd_o,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int SMP_W = 7 + NUM_DIGITS;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SMP_W-1:0]        sync1_q, sync1_d;
  logic [SMP_W-1:0]        sync2_q, sync2_d;
  logic [SMP_W-1:0]        prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  rd_state_e               state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  seg_t                    smp_seg;
  logic [NUM_DIGITS-1:0]   smp_an;
  logic                    an_onehot;
  logic                    changed;
  logic                    commit;
  logic [IDX_W-1:0]        pos;
  hex_t                    dec_hex;
  logic                    dec_match;

  assign smp_seg   = sync2_q[SMP_W-1:NUM_DIGITS];
  assign smp_an    = sync2_q[NUM_DIGITS-1:0];
  assign an_onehot = $onehot(~smp_an);
  assign changed   = (sync2_q != prev_q);

  seg_decode u_dec (
    .seg_i   (smp_seg),
    .hex_o   (dec_hex),
    .match_o (dec_match)
  );

  always_comb begin
    sync1_d  = {seg, an};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    state_d  = state_q;
    commit   = 1'b0;
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    idx_d    = idx_q;
    pos      = '0;

    if (changed)               cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!smp_an[i]) pos = IDX_W'(i);
    end

    case (state_q)
      IDLE: begin
        if (an_onehot) state_d = TRACK;
      end
      TRACK: begin
        if (!an_onehot) begin
          state_d = IDLE;
        end else if (cnt_d == CNT_MAX) begin
          commit  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // One commit per window; only a new sample re-arms tracking.
        if (changed) state_d = an_onehot ? TRACK : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      upd_d = 1'b1;
      idx_d = pos;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (pos == IDX_W'(i)) begin
          if (dec_match) begin
            digits_d[4*i +: 4] = dec_hex;
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else begin
            err_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      upd_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      idx_q    <= idx_d;
    end
  end

  assign digits_o  = digits_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign upd_o     = upd_q;
  assign upd_idx_o = idx_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed scenarios plus random bus
// traffic, all compared cycle by cycle against a run-length reference model.
module tb_seven_seg_reader;

  localparam int ND = 2;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] digits_o;
  logic [1:0] valid_o;
  logic [1:0] err_o;
  logic       upd_o;
  logic [0:0] upd_idx_o;

  seven_seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg       (seg),
    .an        (an),
    .digits_o  (digits_o),
    .valid_o   (valid_o),
    .err_o     (err_o),
    .upd_o     (upd_o),
    .upd_idx_o (upd_idx_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_upd = 0;

  // Reference model: the synchronised sample stream is a 2-cycle delayed copy
  // of the bus; a commit fires when a run of identical samples reaches SC long
  // while exactly one anode is low.
  logic [8:0] p1, p2, pp;
  int         run;
  logic [7:0] m_dig;
  logic [1:0] m_val, m_err;
  logic       m_upd;
  logic [0:0] m_idx;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0:  enc = 7'b1000000;  1:  enc = 7'b1111001;
      2:  enc = 7'b0100100;  3:  enc = 7'b0110000;
      4:  enc = 7'b0011001;  5:  enc = 7'b0010010;
      6:  enc = 7'b0000010;  7:  enc = 7'b1111000;
      8:  enc = 7'b0000000;  9:  enc = 7'b0010000;
      10: enc = 7'b0001000;  11: enc = 7'b0000011;
      12: enc = 7'b1000110;  13: enc = 7'b0100001;
      14: enc = 7'b0000110;  15: enc = 7'b0001110;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic int ref_decode(input logic [6:0] s);
    ref_decode = -1;
    for (int k = 0; k < 16; k++) if (enc(k) == s) ref_decode = k;
  endfunction

  task automatic model_reset();
    p1 = '1; p2 = '1; pp = '1; run = 0;
    m_dig = '0; m_val = '0; m_err = '0; m_upd = 1'b0; m_idx = '0;
  endtask

  task automatic model_edge();
    int d, pos;
    if (p2 != pp) run = 1;
    else          run = run + 1;
    m_upd = 1'b0;
    if (run == SC && (p2[1:0] == 2'b10 || p2[1:0] == 2'b01)) begin
      pos   = (p2[1:0] == 2'b10) ? 0 : 1;
      m_upd = 1'b1;
      m_idx = pos[0:0];
      d     = ref_decode(p2[8:2]);
      if (d >= 0) begin
        m_dig[pos*4 +: 4] = d[3:0];
        m_val[pos] = 1'b1;
        m_err[pos] = 1'b0;
      end else begin
        m_err[pos] = 1'b1;
      end
    end
    pp = p2;
    p2 = p1;
    p1 = {seg, an};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("upd",    32'(upd_o),     32'(m_upd));
    chk("idx",    32'(upd_idx_o), 32'(m_idx));
    chk("digits", 32'(digits_o),  32'(m_dig));
    chk("valid",  32'(valid_o),   32'(m_val));
    chk("err",    32'(err_o),     32'(m_err));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else          model_edge();
      #1;
      if (upd_o) n_upd++;
      check_all();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_digits"}, 32'(digits_o),  32'h0);
    chk({tag, "_valid"},  32'(valid_o),   32'h0);
    chk({tag, "_err"},    32'(err_o),     32'h0);
    chk({tag, "_upd"},    32'(upd_o),     32'h0);
    chk({tag, "_idx"},    32'(upd_idx_o), 32'h0);
  endtask

  initial begin
    int pulse_edge, base;
    logic [7:0] dig_snap;

    // Reset
    reset_n = 1'b0; seg = 7'h7F; an = 2'b11;
    model_reset();
    cyc(3);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Glitch-free commit of '2' on position 0: pulse on edge 6
    seg = 7'b0100100; an = 2'b10;
    n_upd = 0; pulse_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      cyc(1);
      if (upd_o) pulse_edge = e;
    end
    chk("t1_edge",  32'(pulse_edge),    32'd6);
    chk("t1_count", 32'(n_upd),         32'd1);
    chk("t1_digit", 32'(digits_o[3:0]), 32'h2);
    chk("t1_valid", 32'(valid_o),       32'b01);
    chk("t1_err",   32'(err_o),         32'b00);
    chk("t1_idx",   32'(upd_idx_o),     32'd0);

    // Multiplexing b / C across both positions
    n_upd = 0;
    for (int r = 0; r < 4; r++) begin
      seg = 7'b0000011; an = 2'b10; cyc(8);
      seg = 7'b1000110; an = 2'b01; cyc(8);
    end
    chk("t2_count",  32'(n_upd),    32'd8);
    chk("t2_digits", 32'(digits_o), 32'hCB);
    chk("t2_valid",  32'(valid_o),  32'b11);

    // Glitch rejection on position 0
    seg = 7'b1111000; an = 2'b10;
    n_upd = 0; cyc(10);
    chk("t3_first", 32'(n_upd), 32'd1);
    n_upd = 0;
    seg = 7'b0000000; cyc(3);
    seg = 7'b1111000; cyc(4);
    chk("t3_glitch_pulses", 32'(n_upd),         32'd0);
    chk("t3_digit",         32'(digits_o[3:0]), 32'h7);
    cyc(6);
    chk("t3_digit_after",   32'(digits_o[3:0]), 32'h7);

    // Undecodable pattern after a valid 5, then cleared by a valid 9
    seg = 7'b0010010; cyc(10);
    n_upd = 0;
    seg = 7'b1111110; cyc(10);
    chk("t4_count", 32'(n_upd),         32'd1);
    chk("t4_err",   32'(err_o[0]),      32'd1);
    chk("t4_digit", 32'(digits_o[3:0]), 32'h5);
    chk("t4_valid", 32'(valid_o[0]),    32'd1);
    seg = 7'b0010000; cyc(10);
    chk("t4_err_clr", 32'(err_o[0]),      32'd0);
    chk("t4_digit9",  32'(digits_o[3:0]), 32'h9);

    // Anode faults: none or both anodes low
    dig_snap = m_dig;
    n_upd = 0;
    seg = 7'b0000000; an = 2'b00; cyc(20);
    an = 2'b11; cyc(20);
    chk("t5_pulses", 32'(n_upd),    32'd0);
    chk("t5_digits", 32'(digits_o), 32'(dig_snap));

    // Random bus traffic
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1:    an = 2'b10;
        2, 3:    an = 2'b01;
        4:       an = 2'b00;
        default: an = 2'b11;
      endcase
      if ($urandom_range(0, 3) != 0) seg = enc($urandom_range(0, 15));
      else                           seg = 7'($urandom_range(0, 127));
      cyc($urandom_range(1, 10));
    end

    // Reset asserted with the counter at 3 on position 1
    seg = 7'h7F; an = 2'b11; cyc(4);
    seg = 7'b0110000; an = 2'b01; cyc(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("t6_async");
    cyc(2);
    reset_n = 1'b1;
    n_upd = 0; pulse_edge = -1; base = 0;
    for (int e = 1; e <= 10; e++) begin
      cyc(1);
      if (e == 1) base = n_upd;
      if (upd_o) pulse_edge = e;
    end
    chk("t6_release_pulse", 32'(base),           32'd0);
    chk("t6_edge",          32'(pulse_edge),     32'd6);
    chk("t6_count",         32'(n_upd),          32'd1);
    chk("t6_digit",         32'(digits_o[7:4]),  32'h3);
    chk("t6_valid",         32'(valid_o),        32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
